// File: rtl/req_arbiter_ctrl.sv
// Registered 4-requester arbiter with fixed-priority or round-robin selection,
// grant locking while the owner holds its request, and timeout pre-emption.
module req_arbiter_ctrl #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         rr_mode_i,
  output logic [N-1:0] grant_o,
  output logic [1:0]   grant_id_o,
  output logic         grant_valid_o,
  output logic         preempt_o
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_HOLD);
  localparam logic [CW-1:0] OneCnt = CW'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [1:0]     grantId_q, grantId_d;
  logic [CW-1:0]  holdCnt_q, holdCnt_d;
  logic [1:0]     rrPtr_q, rrPtr_d;
  logic           preempt_q, preempt_d;

  logic           doArb;
  logic [N-1:0]   cand;
  logic [N-1:0]   others;
  logic [1:0]     winner;

  // Later matches overwrite earlier ones, so each loop runs in reverse priority order.
  function automatic logic [1:0] pickWinner(input logic [N-1:0] c, input logic rr,
                                            input logic [1:0] ptr);
    logic [1:0] w;
    logic [1:0] idx;
    w = 2'd0;
    if (!rr) begin
      for (int i = 0; i < N; i++)
        if (c[i]) w = 2'(i);
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = ptr + 2'(k);
        if (c[idx]) w = idx;
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    grantId_d = grantId_q;
    holdCnt_d = holdCnt_q;
    rrPtr_d   = rrPtr_q;
    preempt_d = 1'b0;
    doArb     = 1'b0;
    cand      = '0;
    others    = req_i & ~grant_q;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          doArb = 1'b1;
          cand  = req_i;
        end
      end
      GRANT: begin
        if (req_i[grantId_q]) begin
          if ((holdCnt_q < MaxCnt) || (others == '0)) begin
            holdCnt_d = (holdCnt_q == MaxCnt) ? OneCnt : holdCnt_q + OneCnt;
          end else begin
            doArb     = 1'b1;
            cand      = others;
            preempt_d = 1'b1;
          end
        end else if (|req_i) begin
          doArb = 1'b1;
          cand  = req_i;
        end else begin
          state_d   = IDLE;
          grant_d   = '0;
          grantId_d = 2'd0;
          holdCnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    winner = pickWinner(cand, rr_mode_i, rrPtr_q);
    if (doArb) begin
      state_d   = GRANT;
      grant_d   = {{(N-1){1'b0}}, 1'b1} << winner;
      grantId_d = winner;
      holdCnt_d = OneCnt;
      rrPtr_d   = winner + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      grantId_q <= 2'd0;
      holdCnt_q <= '0;
      rrPtr_q   <= 2'd0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      grantId_q <= grantId_d;
      holdCnt_q <= holdCnt_d;
      rrPtr_q   <= rrPtr_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = grantId_q;
  assign grant_valid_o = |grant_q;
  assign preempt_o     = preempt_q;

endmodule

// File: tb/tb_req_arbiter_ctrl.sv
// Self-checking bench for req_arbiter_ctrl: directed scenarios plus random
// traffic compared against an owner/timer model of the arbitration rules.
module tb_req_arbiter_ctrl;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       rr_mode = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  // Model: who owns the resource (-1 = nobody), how long they have held it,
  // and where the next round-robin search starts.
  int mOwner = -1;
  int mHold = 0;
  int mPtr = 0;
  bit mPreempt = 0;

  req_arbiter_ctrl #(.N(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req),
    .rr_mode_i(rr_mode),
    .grant_o(grant),
    .grant_id_o(grant_id),
    .grant_valid_o(grant_valid),
    .preempt_o(preempt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] c, input bit rr, input int ptr);
    if (!rr) begin
      for (int i = 3; i >= 0; i--) if (c[i]) return i;
    end else begin
      for (int k = 0; k < 4; k++) if (c[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelEdge(input logic [3:0] r, input bit rr);
    int w;
    logic [3:0] oth;
    w = -1;
    mPreempt = 0;
    if (mOwner < 0) begin
      if (r != 0) w = pick(r, rr, mPtr);
    end else if (r[mOwner]) begin
      oth = r;
      oth[mOwner] = 1'b0;
      if (mHold < MAX_HOLD || oth == 0) begin
        mHold = (mHold == MAX_HOLD) ? 1 : mHold + 1;
      end else begin
        w = pick(oth, rr, mPtr);
        mPreempt = 1;
      end
    end else if (r != 0) begin
      w = pick(r, rr, mPtr);
    end else begin
      mOwner = -1;
      mHold = 0;
    end
    if (w >= 0) begin
      mOwner = w;
      mHold = 1;
      mPtr = (w + 1) % 4;
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mHold = 0;
    mPtr = 0;
    mPreempt = 0;
  endtask

  task automatic checkInvariants();
    logic [3:0] g;
    g = grant;
    checkOutput("onehot0", 32'($onehot0(g)), 32'd1);
    checkOutput("valid_consistent", 32'(grant_valid), 32'(|g));
    if (g != 4'b0000)
      checkOutput("id_consistent", 32'(4'b0001 << grant_id), 32'(g));
    else
      checkOutput("id_idle", 32'(grant_id), 32'd0);
  endtask

  task automatic checkModel();
    logic [3:0] expG;
    expG = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
    checkOutput("grant", 32'(grant), 32'(expG));
    checkOutput("grant_id", 32'(grant_id), (mOwner < 0) ? 32'd0 : 32'(mOwner));
    checkOutput("preempt", 32'(preempt), 32'(mPreempt));
    checkInvariants();
  endtask

  // Inputs change 1 time unit after a rising edge, then one clock edge is
  // taken, the model advances, and outputs are sampled 1 unit after it.
  task automatic applyStimulus(input logic [3:0] r, input bit rr);
    req = r;
    rr_mode = rr;
    @(posedge clk);
    modelEdge(r, rr);
    #1;
    checkModel();
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_preempt", 32'(preempt), 32'd0);
    checkOutput("reset_valid", 32'(grant_valid), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    bit rr;

    // Reset with everyone requesting: nothing granted until release.
    req = 4'b1111;
    rr_mode = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t1_grant_in_reset", 32'(grant), 32'd0);
    checkOutput("t1_id_in_reset", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 0);
    checkOutput("t1_first_grant", 32'(grant), 32'h8);
    checkOutput("t1_first_id", 32'(grant_id), 32'd3);

    // Fixed priority handover without an idle bubble.
    applyStimulus(4'b0000, 0);
    applyStimulus(4'b0110, 0);
    checkOutput("t2_grant2", 32'(grant), 32'h4);
    applyStimulus(4'b0010, 0);
    checkOutput("t2_grant1", 32'(grant), 32'h2);
    applyStimulus(4'b0000, 0);
    checkOutput("t2_idle", 32'(grant), 32'h0);

    // A lone requester never times out.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0100, 0);
      checkOutput("t4_grant", 32'(grant), 32'h4);
      checkOutput("t4_no_preempt", 32'(preempt), 32'd0);
    end

    // Owner 3 is pre-empted by requester 0 after MAX_HOLD cycles.
    applyStimulus(4'b0000, 0);
    for (int i = 1; i <= MAX_HOLD + 1; i++) applyStimulus(4'b1001, 0);
    checkOutput("t5_preempt_grant", 32'(grant), 32'h1);
    checkOutput("t5_preempt_pulse", 32'(preempt), 32'd1);
    applyStimulus(4'b1000, 0);
    checkOutput("t5_win_back", 32'(grant), 32'h8);
    checkOutput("t5_pulse_cleared", 32'(preempt), 32'd0);

    // Round-robin rotation from a freshly reset pointer.
    doReset();
    for (int e = 1; e <= 4 * MAX_HOLD + 1; e++) begin
      applyStimulus(4'b1111, 1);
      checkOutput("t3_rotate_id", 32'(grant_id), 32'(((e - 1) / MAX_HOLD) % 4));
      checkOutput("t3_pulse", 32'(preempt), 32'((e > 1) && ((e - 1) % MAX_HOLD == 0)));
    end

    // Asynchronous reset between edges, then round-robin from pointer 0.
    doReset();
    applyStimulus(4'b1010, 1);
    checkOutput("t6_rr_after_reset", 32'(grant), 32'h2);

    // Random traffic: requests tend to persist so holds and timeouts occur.
    r = 4'b0000;
    rr = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      if (mOwner >= 0 && $urandom_range(15) == 0) r[mOwner] = 1'b0;
      if ($urandom_range(7) == 0) rr = bit'($urandom_range(1));
      if ($urandom_range(199) == 0) doReset();
      applyStimulus(r, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
